fir_coef_ctrl: RTL and testbench
================================

Name: fir_coef_ctrl

Overview:
- Runtime coefficient manager and sequencer for the H-tap FIR datapath (filtro_fir-style: 3-register pipeline, sync active-high reset on the filter side).
- Accepts tap writes over a valid/ready config port into a shadow bank.
- On commit, swaps shadow into the active bank, aligned to a sample strobe.
- Flushes the filter and gates its output-valid until the pipeline holds only post-swap data.

Parameters:
- H, 13, number of taps.
- CW, 9, coefficient width (signed, Q(COEF_F)).
- COEFFS_INIT, {9'sd128, (H-1){9'sd0}}, packed {c0..c(H-1)} loaded into the active bank at reset (delta, 1.0 in Q7).
- AW (localparam), clog2(H), tap address width (4 for H=13).
- FLUSH_CYCLES (localparam), H+2, clocks from end of flush until the filter output is fully valid.

Ports:
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- cfg_valid, in, 1, tap write request.
- cfg_ready, out, 1, write accepted when cfg_valid && cfg_ready.
- cfg_addr, in, AW, tap index 0..H-1.
- cfg_data, in, CW, signed coefficient.
- cfg_commit, in, 1, request swap of shadow into active (single-cycle strobe).
- sample_en, in, 1, sample-boundary strobe; a swap occurs only on this strobe.
- coeffs_vector, out, H*CW, active bank, packed {c0..c(H-1)}, drives the FIR coefficient input.
- fir_flush, out, 1, one-cycle pulse to the FIR sync reset.
- out_valid, out, 1, high when FIR dout reflects only the current bank.
- bank_armed, out, 1, high in ARMED.
- cfg_err, out, 1, one-cycle error pulse.

Behaviour:
- Reset (async, rst_n=0):
  - active=COEFFS_INIT, shadow=0, write mask=0, fill counter=0.
  - state=FILL, cfg_ready=0, fir_flush=0, out_valid=0, bank_armed=0, cfg_err=0.
- FILL:
  - Counter increments each clk; on reaching FLUSH_CYCLES-1, goes to RUN and out_valid rises on the same edge.
  - After reset, out_valid first high at clock edge 15 (H=13).
  - cfg_ready=0.
- RUN:
  - cfg_ready=1, out_valid=1.
  - Accepted write: shadow[addr]<=data, mask[addr]<=1. Rewriting a tap overwrites it.
  - cfg_addr>=H: write consumed, ignored, cfg_err pulse, mask unchanged.
  - cfg_commit with mask all-ones goes to ARMED. With mask incomplete: cfg_err pulse, stay in RUN, shadow and mask kept.
  - Write and commit in the same cycle: the write is applied first, and the commit evaluates the updated mask.
- ARMED:
  - cfg_ready=0, bank_armed=1, out_valid stays 1.
  - Waits for sample_en, then goes to SWAP. sample_en on the same cycle ARMED is entered does not count.
- SWAP (1 cycle):
  - active<=shadow, mask<=0, fir_flush=1, out_valid=0, then goes to FILL.
  - coeffs_vector changes on the edge that ends SWAP.
- cfg_commit outside RUN: ignored, cfg_err pulse.
- cfg_valid while cfg_ready=0: not consumed; the master holds it (standard valid/ready, no drop).
- out_valid is low from SWAP through the end of FILL: FLUSH_CYCLES+1 cycles total.
- fir_flush is registered and glitch-free.
- Width rules: coefficients are stored as-is, with no scaling or saturation. Packing matches c0 in the MSB slice.
- Async reset mid-operation (any state): immediate return to reset values. The armed swap is lost, and active reverts to COEFFS_INIT.
- State encoding: FILL=2'd0, RUN=2'd1, ARMED=2'd2, SWAP=2'd3.

Decomposition:
- Shared package fir_pkg holds:
  - H, CW, DATA_F, COEF_F defaults;
  - clog2 function;
  - state encoding constants;
  - delta coefficient constant.
- One sub-module, fir_coef_bank: holds the shadow regs, write mask, all-written flag, and active regs with a swap strobe.
- The FSM and fill counter stay in fir_coef_ctrl.

Test Plan:
- Release rst_n, no stimulus -> coeffs_vector = {128, 0 x12}; out_valid=0 for edges 1-14, =1 at edge 15; cfg_ready=1 from edge 15.
- Write taps 0..12 with value 16*(k+1) mod 256 (signed 9b), commit, then sample_en 5 clocks later -> bank_armed=1 for 5 cycles; fir_flush high exactly 1 cycle; coeffs_vector updated at the SWAP edge; out_valid low 16 cycles; FIR (H=13) dout afterwards matches a golden model using the new taps.
- Write taps 0..11 only, commit -> cfg_err 1 cycle, state RUN, no swap. Then write tap 12 and commit in the same cycle -> ARMED.
- cfg_addr=13 with data 9'sd55 -> cfg_err pulse, shadow unchanged, mask unchanged, subsequent full load still swaps correctly.
- cfg_valid held high during ARMED and FILL -> no handshake until RUN, then accepted exactly once. cfg_commit during FILL -> cfg_err, ignored.
- Assert rst_n=0 asynchronously mid-ARMED (between clock edges) -> outputs return to reset values without waiting for a clock edge; coeffs_vector = delta; no fir_flush pulse.

Source files
------------

// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR coefficient manager: default filter
// geometry, fixed-point formats, controller state encoding, the delta
// coefficient used as the power-up impulse response, and a constant-safe
// ceil(log2) helper used to size address and counter fields.
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam int FIR_H      = 13;   // number of taps
    localparam int FIR_CW     = 9;    // coefficient width, signed
    localparam int FIR_DATA_F = 8;    // fractional bits of FIR sample data
    localparam int FIR_COEF_F = 7;    // fractional bits of coefficients (Q7)

    // 1.0 in Q7: tap 0 of the power-up bank, making the filter a pass-through.
    localparam logic [FIR_CW-1:0] FIR_COEF_DELTA = 9'sd128;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ARMED = 2'd2,
        ST_SWAP  = 2'd3
    } fir_state_e;

    // ceil(log2(n)), with a floor of 0 for n <= 1.
    function automatic int fir_clog2(input int n);
        int r;
        r = 32'sd0;
        for (int v = n - 32'sd1; v > 32'sd0; v = v >>> 32'sd1) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_coef_ctrl_if.sv
// ---------------------------------------------------------------------------
// fir_coef_ctrl_if
// Coefficient configuration bus: valid/ready tap writes plus a commit strobe.
//   cfg_valid  master->slave  tap write request, held until accepted
//   cfg_ready  slave->master  write accepted when cfg_valid && cfg_ready
//   cfg_addr   master->slave  tap index 0..H-1
//   cfg_data   master->slave  signed coefficient
//   cfg_commit master->slave  single-cycle request to swap shadow -> active
// ---------------------------------------------------------------------------
interface fir_coef_ctrl_if
    import fir_pkg::*;
#(
    parameter int H  = FIR_H,
    parameter int CW = FIR_CW
);
    localparam int AW = fir_clog2(H);

    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [AW-1:0]        cfg_addr;
    logic signed [CW-1:0] cfg_data;
    logic                 cfg_commit;

    modport master (
        output cfg_valid,
        output cfg_addr,
        output cfg_data,
        output cfg_commit,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_addr,
        input  cfg_data,
        input  cfg_commit,
        output cfg_ready
    );

endinterface

// File: rtl/fir_coef_bank.sv
// ---------------------------------------------------------------------------
// fir_coef_bank
// Double-buffered coefficient storage. Writes land in a shadow bank and set
// the matching bit of a write mask; a swap strobe copies the whole shadow
// bank into the active bank in one edge and clears the mask.
//   clk, rst_n      clock, asynchronous active-low reset
//   i_wr_en         write one shadow tap (address already range-checked)
//   i_wr_addr       tap index
//   i_wr_data       coefficient value, stored unmodified
//   i_swap          copy shadow -> active, clear mask
//   o_active        active bank packed {c0..c(H-1)}, c0 in the MSB slice
//   o_all_written   every tap written, counting a write in this same cycle
// ---------------------------------------------------------------------------
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int              H           = FIR_H,
    parameter int              CW          = FIR_CW,
    parameter int              AW          = fir_clog2(FIR_H),
    parameter logic [H*CW-1:0] COEFFS_INIT = {FIR_COEF_DELTA, {((FIR_H-1)*FIR_CW){1'b0}}}
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [CW-1:0]    i_wr_data,
    input  logic             i_swap,
    output logic [H*CW-1:0]  o_active,
    output logic             o_all_written
);

    logic [CW-1:0]   r_shadow [H];
    logic [H-1:0]    r_mask;
    logic [H*CW-1:0] r_active;
    logic [H-1:0]    w_wr_onehot;
    logic [H*CW-1:0] w_shadow_packed;

    // Decode the write address into a one-hot tap select.
    always_comb begin
        w_wr_onehot = {H{1'b0}};
        for (int k = 0; k < H; k++) begin
            if (i_wr_en && (i_wr_addr == AW'(k))) begin
                w_wr_onehot[k] = 1'b1;
            end else begin
                w_wr_onehot[k] = 1'b0;
            end
        end
    end

    // Pack the shadow bank with tap 0 in the most significant slice.
    always_comb begin
        w_shadow_packed = {(H*CW){1'b0}};
        for (int k = 0; k < H; k++) begin
            w_shadow_packed[(H-1-k)*CW +: CW] = r_shadow[k];
        end
    end

    // Including this cycle's write lets a write+commit pair arm the swap.
    assign o_all_written = &(r_mask | w_wr_onehot);
    assign o_active      = r_active;

    // Shadow taps and write mask; a swap clears the mask but keeps the taps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < H; k++) begin
                r_shadow[k] <= {CW{1'b0}};
            end
            r_mask <= {H{1'b0}};
        end else if (i_swap) begin
            r_mask <= {H{1'b0}};
        end else begin
            for (int k = 0; k < H; k++) begin
                if (w_wr_onehot[k]) begin
                    r_shadow[k] <= i_wr_data;
                end
            end
            r_mask <= r_mask | w_wr_onehot;
        end
    end

    // Active bank, loaded from the shadow bank only on the swap strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= COEFFS_INIT;
        end else if (i_swap) begin
            r_active <= w_shadow_packed;
        end else begin
            r_active <= r_active;
        end
    end

endmodule

// File: rtl/fir_coef_ctrl.sv
// ---------------------------------------------------------------------------
// fir_coef_ctrl
// Runtime coefficient manager for an H-tap FIR. Tap writes are collected in
// a shadow bank; once all taps are written a commit arms a swap, which is
// executed on the next sample strobe. The swap pulses the filter's sync
// reset and holds out_valid low until the pipeline has refilled with data
// produced by the new bank.
//   clk, rst_n         clock, asynchronous active-low reset
//   cfg                configuration bus (slave side)
//   i_sample_en        sample-boundary strobe; swaps happen only here
//   o_coeffs_vector    active bank packed {c0..c(H-1)}
//   o_fir_flush        one-cycle pulse to the FIR sync reset
//   o_out_valid        FIR output reflects only the current bank
//   o_bank_armed       swap pending, waiting for i_sample_en
//   o_cfg_err          one-cycle pulse: bad address or rejected commit
// ---------------------------------------------------------------------------
module fir_coef_ctrl
    import fir_pkg::*;
#(
    parameter int              H           = FIR_H,
    parameter int              CW          = FIR_CW,
    parameter logic [H*CW-1:0] COEFFS_INIT = {FIR_COEF_DELTA, {((FIR_H-1)*FIR_CW){1'b0}}}
)(
    input  logic             clk,
    input  logic             rst_n,
    fir_coef_ctrl_if.slave   cfg,
    input  logic             i_sample_en,
    output logic [H*CW-1:0]  o_coeffs_vector,
    output logic             o_fir_flush,
    output logic             o_out_valid,
    output logic             o_bank_armed,
    output logic             o_cfg_err
);

    localparam int AW           = fir_clog2(H);
    localparam int FLUSH_CYCLES = H + 32'sd2;
    localparam int CNTW         = fir_clog2(FLUSH_CYCLES);
    localparam logic [CNTW-1:0] FILL_LAST = CNTW'(FLUSH_CYCLES - 32'sd1);

    fir_state_e      r_state;
    logic [CNTW-1:0] r_fill_cnt;
    logic            r_cfg_ready;
    logic            r_fir_flush;
    logic            r_out_valid;
    logic            r_bank_armed;
    logic            r_cfg_err;

    logic w_wr_fire;
    logic w_addr_ok;
    logic w_wr_en;
    logic w_wr_bad;
    logic w_all_written;
    logic w_commit_ok;
    logic w_commit_bad;
    logic w_swap;

    // cfg_ready is high exactly in RUN, so a fired handshake implies RUN.
    assign w_wr_fire    = cfg.cfg_valid & r_cfg_ready;
    // One extra bit keeps the range check correct when H is a power of two.
    assign w_addr_ok    = ({1'b0, cfg.cfg_addr} < (AW+1)'(H));
    assign w_wr_en      = w_wr_fire & w_addr_ok;
    assign w_wr_bad     = w_wr_fire & ~w_addr_ok;
    assign w_commit_ok  = cfg.cfg_commit & (r_state == ST_RUN) & w_all_written;
    assign w_commit_bad = cfg.cfg_commit & ~w_commit_ok;
    assign w_swap       = (r_state == ST_SWAP);

    fir_coef_bank #(
        .H           (H),
        .CW          (CW),
        .AW          (AW),
        .COEFFS_INIT (COEFFS_INIT)
    ) u_bank (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_wr_en       (w_wr_en),
        .i_wr_addr     (cfg.cfg_addr),
        .i_wr_data     (cfg.cfg_data),
        .i_swap        (w_swap),
        .o_active      (o_coeffs_vector),
        .o_all_written (w_all_written)
    );

    // Control FSM: refill countdown, handshake enable and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_FILL;
            r_fill_cnt   <= {CNTW{1'b0}};
            r_cfg_ready  <= 1'b0;
            r_fir_flush  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_bank_armed <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_cfg_err   <= w_wr_bad | w_commit_bad;
            r_fir_flush <= 1'b0;
            case (r_state)
                ST_FILL: begin
                    if (r_fill_cnt == FILL_LAST) begin
                        r_state     <= ST_RUN;
                        r_fill_cnt  <= {CNTW{1'b0}};
                        r_cfg_ready <= 1'b1;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_fill_cnt  <= r_fill_cnt + CNTW'(32'd1);
                    end
                end
                ST_RUN: begin
                    if (w_commit_ok) begin
                        r_state      <= ST_ARMED;
                        r_cfg_ready  <= 1'b0;
                        r_bank_armed <= 1'b1;
                    end else begin
                        r_state      <= ST_RUN;
                    end
                end
                ST_ARMED: begin
                    // Only reached one edge after the commit, so a strobe
                    // coincident with the commit is never taken here.
                    if (i_sample_en) begin
                        r_state      <= ST_SWAP;
                        r_bank_armed <= 1'b0;
                        r_out_valid  <= 1'b0;
                        r_fir_flush  <= 1'b1;
                    end else begin
                        r_state      <= ST_ARMED;
                    end
                end
                ST_SWAP: begin
                    r_state    <= ST_FILL;
                    r_fill_cnt <= {CNTW{1'b0}};
                end
                default: begin
                    r_state      <= ST_FILL;
                    r_fill_cnt   <= {CNTW{1'b0}};
                    r_cfg_ready  <= 1'b0;
                    r_out_valid  <= 1'b0;
                    r_bank_armed <= 1'b0;
                end
            endcase
        end
    end

    assign cfg.cfg_ready = r_cfg_ready;
    assign o_fir_flush   = r_fir_flush;
    assign o_out_valid   = r_out_valid;
    assign o_bank_armed  = r_bank_armed;
    assign o_cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fir_coef_ctrl
// Self-checking bench for fir_coef_ctrl. A behavioural model tracks the
// active/shadow banks, which taps have been written and how many edges of
// refill remain, and predicts every status output and the packed bank.
// ---------------------------------------------------------------------------
module tb_fir_coef_ctrl;
    import fir_pkg::*;

    localparam int H          = 13;
    localparam int CW         = 9;
    localparam int AW         = fir_clog2(H);
    localparam int FILL_EDGES = H + 2;   // edges from reset/swap-end to RUN

    logic            clk;
    logic            rst_n;
    logic            sample_en;
    logic [H*CW-1:0] coeffs;
    logic            fir_flush;
    logic            out_valid;
    logic            bank_armed;
    logic            cfg_err;

    fir_coef_ctrl_if #(.H(H), .CW(CW)) cfg_bus ();

    fir_coef_ctrl #(.H(H), .CW(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg             (cfg_bus),
        .i_sample_en     (sample_en),
        .o_coeffs_vector (coeffs),
        .o_fir_flush     (fir_flush),
        .o_out_valid     (out_valid),
        .o_bank_armed    (bank_armed),
        .o_cfg_err       (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    // ---------------- behavioural model ----------------
    logic [CW-1:0] m_active [H];
    logic [CW-1:0] m_shadow [H];
    bit            m_written [H];
    int            m_wait;      // edges still to go before filtering resumes
    bit            m_armed;
    bit            m_swap;
    bit            m_err;
    bit            hs;          // handshake happened on the last edge

    task automatic model_reset();
        for (int k = 0; k < H; k++) begin
            m_active[k]  = (k == 0) ? CW'(128) : CW'(0);
            m_shadow[k]  = CW'(0);
            m_written[k] = 1'b0;
        end
        m_wait  = FILL_EDGES;
        m_armed = 1'b0;
        m_swap  = 1'b0;
        m_err   = 1'b0;
    endtask

    function automatic bit model_run();
        return (m_wait == 0) && !m_armed && !m_swap;
    endfunction

    function automatic bit all_written();
        for (int k = 0; k < H; k++) if (!m_written[k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [H*CW-1:0] exp_coeffs();
        logic [H*CW-1:0] v;
        for (int k = 0; k < H; k++) v[(H-1-k)*CW +: CW] = m_active[k];
        return v;
    endfunction

    // {cfg_ready, out_valid, bank_armed, fir_flush, cfg_err}
    function automatic logic [4:0] exp_flags();
        return {model_run(), (m_wait == 0) && !m_swap, m_armed, m_swap, m_err};
    endfunction

    function automatic logic [4:0] dut_flags();
        return {cfg_bus.cfg_ready, out_valid, bank_armed, fir_flush, cfg_err};
    endfunction

    // Advance one clock and apply the rules to the model with the inputs
    // present at that edge. Outputs are sampled 1 time unit later.
    task automatic step();
        bit            pre_ready, run, v, c, s;
        logic [AW-1:0] a;
        logic [CW-1:0] d;
        pre_ready = cfg_bus.cfg_ready;
        v = cfg_bus.cfg_valid; c = cfg_bus.cfg_commit; s = sample_en;
        a = cfg_bus.cfg_addr;  d = cfg_bus.cfg_data;
        @(posedge clk);
        hs    = v && pre_ready;
        m_err = 1'b0;
        run   = model_run();
        if (m_swap) begin
            for (int k = 0; k < H; k++) begin
                m_active[k]  = m_shadow[k];
                m_written[k] = 1'b0;
            end
            m_swap = 1'b0;
            m_wait = FILL_EDGES;
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (m_armed) begin
            if (s) begin
                m_armed = 1'b0;
                m_swap  = 1'b1;
            end
        end else begin
            if (v) begin
                if (int'(a) < H) begin
                    m_shadow[a]  = d;
                    m_written[a] = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (c) begin
                if (all_written()) m_armed = 1'b1;
                else               m_err   = 1'b1;
            end
        end
        if (c && !run) m_err = 1'b1;
        #1;
        edge_n++;
    endtask

    // Master side of a single tap write: hold valid until it is taken.
    task automatic write_tap(input int addr, input logic [CW-1:0] data, input bit commit);
        cfg_bus.cfg_valid  = 1'b1;
        cfg_bus.cfg_addr   = AW'(addr);
        cfg_bus.cfg_data   = data;
        cfg_bus.cfg_commit = commit;
        hs = 1'b0;
        for (int n = 0; n < 64 && !hs; n++) begin
            step();
            cfg_bus.cfg_commit = 1'b0;
        end
        if (!hs) begin
            errors++; checks++;
            $display("FAIL write_tap_timeout addr=%0d: no handshake within 64 cycles", addr);
        end
        cfg_bus.cfg_valid = 1'b0;
    endtask

    task automatic load_random(input int upto);
        for (int k = 0; k < upto; k++) write_tap(k, CW'($urandom), 1'b0);
    endtask

    task automatic commit_pulse();
        cfg_bus.cfg_commit = 1'b1;
        step();
        cfg_bus.cfg_commit = 1'b0;
    endtask

    // Fire a pending swap after a random delay and wait for the refill.
    task automatic drain();
        if (m_armed) begin
            repeat ($urandom_range(0, 3)) step();
            sample_en = 1'b1;
            step();
            sample_en = 1'b0;
        end
        for (int n = 0; n < 40 && !model_run(); n++) step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int first_valid;
        first_valid = -1;
        sample_en = 1'b0;
        cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_commit = 1'b0;
        cfg_bus.cfg_addr = '0;    cfg_bus.cfg_data = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #12;
        model_reset();
        checks++;
        if (coeffs !== exp_coeffs())
            begin errors++; $display("FAIL reset_coeffs got=%h want=%h", coeffs, exp_coeffs()); end
        checks++;
        if (dut_flags() !== 5'b00000)
            begin errors++; $display("FAIL reset_flags got=%b want=00000", dut_flags()); end
        @(posedge clk); #1;
        rst_n  = 1'b1;
        edge_n = 0;
        for (int i = 0; i < FILL_EDGES + 2; i++) begin
            step();
            checks++;
            if (dut_flags() !== exp_flags())
                begin errors++; $display("FAIL fill_flags edge=%0d got=%b want=%b", edge_n, dut_flags(), exp_flags()); end
            if (out_valid === 1'b1 && first_valid < 0) first_valid = edge_n;
        end
        checks++;
        if (first_valid != 15)
            begin errors++; $display("FAIL first_valid_edge got=%0d want=15", first_valid); end
    endtask

    task automatic test_plan_swap();
        int n_armed, n_flush, n_low, chg;
        logic [H*CW-1:0] old;
        for (int k = 0; k < H; k++) write_tap(k, CW'((16 * (k + 1)) % 256), 1'b0);
        commit_pulse();
        checks++;
        if (dut_flags() !== exp_flags())
            begin errors++; $display("FAIL plan_commit got=%b want=%b", dut_flags(), exp_flags()); end
        n_armed = int'(bank_armed); n_flush = 0; n_low = 0; chg = -1; old = coeffs;
        for (int i = 0; i < 24; i++) begin
            sample_en = (i == 4);
            step();
            sample_en = 1'b0;
            checks++;
            if (dut_flags() !== exp_flags())
                begin errors++; $display("FAIL plan_flags i=%0d got=%b want=%b", i, dut_flags(), exp_flags()); end
            checks++;
            if (coeffs !== exp_coeffs())
                begin errors++; $display("FAIL plan_coeffs i=%0d got=%h want=%h", i, coeffs, exp_coeffs()); end
            n_armed += int'(bank_armed);
            n_flush += int'(fir_flush);
            n_low   += int'(!out_valid);
            if (chg < 0 && coeffs !== old) chg = i;
        end
        checks++;
        if (n_armed != 5) begin errors++; $display("FAIL armed_cycles got=%0d want=5", n_armed); end
        checks++;
        if (n_flush != 1) begin errors++; $display("FAIL flush_cycles got=%0d want=1", n_flush); end
        checks++;
        if (n_low != 16) begin errors++; $display("FAIL valid_low_cycles got=%0d want=16", n_low); end
        checks++;
        if (chg != 5) begin errors++; $display("FAIL swap_edge got=%0d want=5", chg); end
    endtask

    task automatic test_incomplete_commit();
        load_random(H - 1);
        commit_pulse();
        checks++;
        if (dut_flags() !== exp_flags() || cfg_err !== 1'b1 || bank_armed !== 1'b0)
            begin errors++; $display("FAIL incomplete_commit got=%b want=%b", dut_flags(), exp_flags()); end
        step();
        checks++;
        if (dut_flags() !== exp_flags())
            begin errors++; $display("FAIL incomplete_after got=%b want=%b", dut_flags(), exp_flags()); end
        write_tap(H - 1, CW'($urandom), 1'b1);
        checks++;
        if (dut_flags() !== exp_flags() || bank_armed !== 1'b1)
            begin errors++; $display("FAIL write_commit_same got=%b want=%b", dut_flags(), exp_flags()); end
        drain();
        checks++;
        if (coeffs !== exp_coeffs())
            begin errors++; $display("FAIL incomplete_swap_coeffs got=%h want=%h", coeffs, exp_coeffs()); end
    endtask

    task automatic test_bad_addr();
        load_random(H - 1);
        write_tap(13, CW'(55), 1'b0);
        checks++;
        if (dut_flags() !== exp_flags() || cfg_err !== 1'b1)
            begin errors++; $display("FAIL bad_addr_err got=%b want=%b", dut_flags(), exp_flags()); end
        commit_pulse();
        checks++;
        if (dut_flags() !== exp_flags() || bank_armed !== 1'b0)
            begin errors++; $display("FAIL bad_addr_mask got=%b want=%b", dut_flags(), exp_flags()); end
        write_tap(15, CW'($urandom), 1'b0);
        write_tap(H - 1, CW'($urandom), 1'b0);
        commit_pulse();
        checks++;
        if (dut_flags() !== exp_flags())
            begin errors++; $display("FAIL bad_addr_arm got=%b want=%b", dut_flags(), exp_flags()); end
        drain();
        checks++;
        if (coeffs !== exp_coeffs())
            begin errors++; $display("FAIL bad_addr_coeffs got=%h want=%h", coeffs, exp_coeffs()); end
    endtask

    task automatic test_hold_valid();
        int            a;
        logic [CW-1:0] d;
        bit            hs_seen, commit_done, do_commit;
        load_random(H);
        commit_pulse();
        a = $urandom_range(0, H - 1);
        d = CW'($urandom);
        hs_seen = 1'b0; commit_done = 1'b0;
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_addr  = AW'(a);
        cfg_bus.cfg_data  = d;
        for (int i = 0; i < 60 && !hs_seen; i++) begin
            sample_en = (i == 2);
            do_commit = !commit_done && !m_swap && m_wait > 0 && m_wait < 10;
            cfg_bus.cfg_commit = do_commit;
            if (do_commit) commit_done = 1'b1;
            step();
            sample_en = 1'b0; cfg_bus.cfg_commit = 1'b0;
            checks++;
            if (dut_flags() !== exp_flags())
                begin errors++; $display("FAIL hold_flags i=%0d got=%b want=%b", i, dut_flags(), exp_flags()); end
            if (hs) hs_seen = 1'b1;
        end
        cfg_bus.cfg_valid = 1'b0;
        checks++;
        if (!hs_seen || !commit_done)
            begin errors++; $display("FAIL hold_handshake got=%0d want=1", hs_seen); end
        for (int k = 0; k < H; k++) if (k != a) write_tap(k, CW'($urandom), 1'b0);
        commit_pulse();
        drain();
        checks++;
        if (coeffs !== exp_coeffs())
            begin errors++; $display("FAIL hold_coeffs got=%h want=%h", coeffs, exp_coeffs()); end
    endtask

    task automatic test_async_reset();
        load_random(H);
        commit_pulse();
        step(); step();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (coeffs !== exp_coeffs())
            begin errors++; $display("FAIL async_coeffs got=%h want=%h", coeffs, exp_coeffs()); end
        checks++;
        if (dut_flags() !== 5'b00000)
            begin errors++; $display("FAIL async_flags got=%b want=00000", dut_flags()); end
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (fir_flush !== 1'b0 || coeffs !== exp_coeffs())
                begin errors++; $display("FAIL async_hold flush=%b got=%h want=%h", fir_flush, coeffs, exp_coeffs()); end
        end
        rst_n = 1'b1;
        for (int i = 0; i < FILL_EDGES; i++) step();
        checks++;
        if (dut_flags() !== exp_flags())
            begin errors++; $display("FAIL async_recover got=%b want=%b", dut_flags(), exp_flags()); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if (!cfg_bus.cfg_valid && $urandom_range(0, 2) == 0) begin
                cfg_bus.cfg_valid = 1'b1;
                cfg_bus.cfg_addr  = AW'($urandom_range(0, 15));
                cfg_bus.cfg_data  = CW'($urandom);
            end
            cfg_bus.cfg_commit = ($urandom_range(0, 9) == 0);
            sample_en          = ($urandom_range(0, 3) == 0);
            step();
            cfg_bus.cfg_commit = 1'b0;
            checks++;
            if (dut_flags() !== exp_flags())
                begin errors++; $display("FAIL rand_flags i=%0d got=%b want=%b", i, dut_flags(), exp_flags()); end
            checks++;
            if (coeffs !== exp_coeffs())
                begin errors++; $display("FAIL rand_coeffs i=%0d got=%h want=%h", i, coeffs, exp_coeffs()); end
            if (hs) cfg_bus.cfg_valid = 1'b0;
        end
        cfg_bus.cfg_valid = 1'b0;
        sample_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_plan_swap();
        test_incomplete_commit();
        test_bad_addr();
        test_hold_valid();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
